// File: rtl/stream_remove_arb.sv
// Round-robin front end for a shared stream_remove datapath.
// Each source posts a per-packet remove command; the winner keeps the grant until the
// remover reports the packet's output last beat on rm_ready.
// Optional: define STREAM_REMOVE_ARB_PKTCNT_EN to add per-source completed-packet counters
// on output pkt_cnt.
module stream_remove_arb #(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned SRC_ID_WD    = $clog2(N_SRC)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_SRC-1:0]              s_valid,
  input  logic [N_SRC*DATA_WD-1:0]      s_data,
  input  logic [N_SRC*DATA_BYTE_WD-1:0] s_keep,
  input  logic [N_SRC-1:0]              s_last,
  output logic [N_SRC-1:0]              s_ready,
  input  logic [N_SRC-1:0]              cmd_valid,
  input  logic [N_SRC*BYTE_CNT_WD-1:0]  cmd_cnt,
  output logic [N_SRC-1:0]              cmd_ready,
  output logic                          m_valid,
  output logic [DATA_WD-1:0]            m_data,
  output logic [DATA_BYTE_WD-1:0]       m_keep,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          rm_valid,
  output logic [BYTE_CNT_WD-1:0]        rm_cnt,
  input  logic                          rm_ready,
  output logic                          busy,
`ifdef STREAM_REMOVE_ARB_PKTCNT_EN
  output logic [N_SRC*16-1:0]           pkt_cnt,
`endif
  output logic [SRC_ID_WD-1:0]          grant_id
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                 state_q;
  logic                   hold_q;      // grant held (BUSY or DRAIN)
  logic [SRC_ID_WD-1:0]   rr_ptr_q;
  logic [SRC_ID_WD-1:0]   grant_id_q;
  logic [BYTE_CNT_WD-1:0] cnt_r;

  logic                   win_found;
  logic [SRC_ID_WD-1:0]   win_id;
  logic [SRC_ID_WD-1:0]   cand;

  logic                   in_busy;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WD-1:0]     sel_data;
  logic [DATA_BYTE_WD-1:0] sel_keep;
  logic                   last_fire;
  logic                   pkt_done;

  // Round-robin search over pending commands, starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = SRC_ID_WD'((32'(rr_ptr_q) + k) % N_SRC);
      if (!win_found && cmd_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign in_busy   = (state_q == StBusy);
  assign sel_valid = s_valid[grant_id_q];
  assign sel_last  = s_last[grant_id_q];
  assign sel_data  = s_data[grant_id_q*DATA_WD +: DATA_WD];
  assign sel_keep  = s_keep[grant_id_q*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign last_fire = in_busy & sel_valid & m_ready & sel_last;
  assign pkt_done  = (last_fire & rm_ready) | ((state_q == StDrain) & rm_ready);

  // Stream mux and handshake steering; everything idles at zero outside BUSY.
  always_comb begin
    cmd_ready = '0;
    s_ready   = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_keep    = '0;
    m_last    = 1'b0;
    // rstn gate keeps cmd_ready quiet while reset is held with requests pending.
    if ((state_q == StIdle) && rstn && win_found) begin
      cmd_ready[win_id] = 1'b1;
    end
    if (in_busy) begin
      m_valid             = sel_valid;
      m_data              = sel_data;
      m_keep              = sel_keep;
      m_last              = sel_last;
      s_ready[grant_id_q] = m_ready;
    end
  end

  assign rm_valid = hold_q;
  assign busy     = hold_q;
  assign rm_cnt   = hold_q ? cnt_r : '0;
  assign grant_id = grant_id_q;

  // Grant FSM: IDLE grants, BUSY forwards the packet, DRAIN waits for the remover's tail beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      hold_q     <= 1'b0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cnt_r      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q    <= StBusy;
            hold_q     <= 1'b1;
            grant_id_q <= win_id;
            cnt_r      <= cmd_cnt[win_id*BYTE_CNT_WD +: BYTE_CNT_WD];
            rr_ptr_q   <= (win_id == SRC_ID_WD'(N_SRC - 1)) ? '0 : win_id + 1'b1;
          end
        end
        StBusy: begin
          // A stray rm_ready before the input last beat is ignored.
          if (last_fire) begin
            if (rm_ready) begin
              state_q <= StIdle;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (rm_ready) begin
            state_q <= StIdle;
            hold_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAM_REMOVE_ARB_PKTCNT_EN
  logic [15:0] pkt_cnt_q [N_SRC];

  // Completed-packet counters, credited to the source holding the grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else if (pkt_done) begin
      pkt_cnt_q[grant_id_q] <= pkt_cnt_q[grant_id_q] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pkt_cnt
    assign pkt_cnt[gi*16 +: 16] = pkt_cnt_q[gi];
  end
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
`endif

endmodule
